// File: rtl/alu_op_decoder.sv
// RV32I decode stage: turns one instruction plus regfile operands into a registered ALU command
// with writeback/branch/memory control, behind a one-entry valid/ready output register.
module alu_op_decoder #(
    parameter int unsigned SHAMT_CHECK = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       alu_function,
    output logic [31:0]      operand_a,
    output logic [31:0]      operand_b,
    output logic [4:0]       rd_addr,
    output logic             rd_we,
    output logic             is_branch,
    output logic             branch_inv,
    output logic             is_jump,
    output logic [31:0]      target,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [4:0] FnAdd  = 5'd1;
    localparam logic [4:0] FnSub  = 5'd2;
    localparam logic [4:0] FnSll  = 5'd3;
    localparam logic [4:0] FnSrl  = 5'd4;
    localparam logic [4:0] FnSra  = 5'd5;
    localparam logic [4:0] FnSeq  = 5'd6;
    localparam logic [4:0] FnSlt  = 5'd7;
    localparam logic [4:0] FnSltu = 5'd8;
    localparam logic [4:0] FnXor  = 5'd9;
    localparam logic [4:0] FnOr   = 5'd10;
    localparam logic [4:0] FnAnd  = 5'd11;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef struct packed {
        logic [4:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        inv;
        logic        jmp;
        logic [31:0] tgt;
        logic        mrd;
        logic        mwr;
        logic        ill;
    } cmd_t;

    cmd_t             cmd_d, cmd_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, ill, wr, shamt_bad;
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j, shamt, jalr_sum;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign rd        = instr[11:7];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt     = {27'b0, instr[24:20]};
    assign shamt_bad = (SHAMT_CHECK != 0) && instr[25];
    assign jalr_sum  = rs1_data + imm_i;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        cmd_d = '0;
        ill   = 1'b0;
        wr    = 1'b0;
        case (opcode)
            OpcOp: begin
                cmd_d.a = rs1_data;
                cmd_d.b = rs2_data;
                wr      = 1'b1;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000: cmd_d.fn = FnAdd;
                        3'b001: cmd_d.fn = FnSll;
                        3'b010: cmd_d.fn = FnSlt;
                        3'b011: cmd_d.fn = FnSltu;
                        3'b100: cmd_d.fn = FnXor;
                        3'b101: cmd_d.fn = FnSrl;
                        3'b110: cmd_d.fn = FnOr;
                        3'b111: cmd_d.fn = FnAnd;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    cmd_d.fn = FnSub;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    cmd_d.fn = FnSra;
                end else begin
                    ill = 1'b1;
                end
                // ALU shifts by the full operand, so trim to the architectural 5 bits here
                if (funct3 == 3'b001 || funct3 == 3'b101) cmd_d.b = {27'b0, rs2_data[4:0]};
            end
            OpcImm: begin
                cmd_d.a = rs1_data;
                cmd_d.b = imm_i;
                wr      = 1'b1;
                case (funct3)
                    3'b000: cmd_d.fn = FnAdd;
                    3'b010: cmd_d.fn = FnSlt;
                    3'b011: cmd_d.fn = FnSltu;
                    3'b100: cmd_d.fn = FnXor;
                    3'b110: cmd_d.fn = FnOr;
                    3'b111: cmd_d.fn = FnAnd;
                    3'b001: begin
                        cmd_d.fn = FnSll;
                        cmd_d.b  = shamt;
                        if (instr[31:26] != 6'b0 || shamt_bad) ill = 1'b1;
                    end
                    3'b101: begin
                        cmd_d.fn = instr[30] ? FnSra : FnSrl;
                        cmd_d.b  = shamt;
                        if (instr[31] || instr[29:26] != 4'b0 || shamt_bad) ill = 1'b1;
                    end
                endcase
            end
            OpcLui: begin
                cmd_d.fn = FnAdd;
                cmd_d.b  = imm_u;
                wr       = 1'b1;
            end
            OpcAuipc: begin
                cmd_d.fn = FnAdd;
                cmd_d.a  = pc;
                cmd_d.b  = imm_u;
                wr       = 1'b1;
            end
            OpcJal, OpcJalr: begin
                cmd_d.fn  = FnAdd;
                cmd_d.a   = pc;
                cmd_d.b   = 32'd4;
                cmd_d.jmp = 1'b1;
                wr        = 1'b1;
                if (opcode == OpcJal) begin
                    cmd_d.tgt = pc + imm_j;
                end else begin
                    cmd_d.tgt = {jalr_sum[31:1], 1'b0};
                    if (funct3 != 3'b000) ill = 1'b1;
                end
            end
            OpcLoad: begin
                cmd_d.fn  = FnAdd;
                cmd_d.a   = rs1_data;
                cmd_d.b   = imm_i;
                cmd_d.mrd = 1'b1;
                wr        = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ill = 1'b1;
            end
            OpcStore: begin
                cmd_d.fn  = FnAdd;
                cmd_d.a   = rs1_data;
                cmd_d.b   = imm_s;
                cmd_d.mwr = 1'b1;
                if (funct3 > 3'b010) ill = 1'b1;
            end
            OpcBranch: begin
                cmd_d.a   = rs1_data;
                cmd_d.b   = rs2_data;
                cmd_d.br  = 1'b1;
                cmd_d.tgt = pc + imm_b;
                case (funct3)
                    3'b000: begin cmd_d.fn = FnSeq;  cmd_d.inv = 1'b1; end
                    3'b001: begin cmd_d.fn = FnSeq;  cmd_d.inv = 1'b0; end
                    3'b100: begin cmd_d.fn = FnSlt;  cmd_d.inv = 1'b1; end
                    3'b101: begin cmd_d.fn = FnSlt;  cmd_d.inv = 1'b0; end
                    3'b110: begin cmd_d.fn = FnSltu; cmd_d.inv = 1'b1; end
                    3'b111: begin cmd_d.fn = FnSltu; cmd_d.inv = 1'b0; end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            cmd_d     = '0;
            cmd_d.ill = 1'b1;
            wr        = 1'b0;
        end
        cmd_d.we = wr && (rd != 5'd0);
        cmd_d.rd = cmd_d.we ? rd : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                cmd_q   <= cmd_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            // A flushed command is dropped, not handed off
            if (valid_q && out_ready && !flush && cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid    = valid_q;
    assign alu_function = cmd_q.fn;
    assign operand_a    = cmd_q.a;
    assign operand_b    = cmd_q.b;
    assign rd_addr      = cmd_q.rd;
    assign rd_we        = cmd_q.we;
    assign is_branch    = cmd_q.br;
    assign branch_inv   = cmd_q.inv;
    assign is_jump      = cmd_q.jmp;
    assign target       = cmd_q.tgt;
    assign mem_rd       = cmd_q.mrd;
    assign mem_wr       = cmd_q.mwr;
    assign illegal      = cmd_q.ill;
    assign dec_count    = cnt_q;

endmodule
